// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared entry type and helpers for the issue queue
package issue_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [9:0]  inst_type;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [4:0]  rf_waddr;
        logic        o_valid;
    } PC_set;

    localparam PC_set PC_SET_NOP = '{
        pc:        32'd0,
        inst:      32'd0,
        inst_type: 10'd1,
        rf_raddr1: 5'd0,
        rf_raddr2: 5'd0,
        rf_waddr:  5'd0,
        o_valid:   1'b0
    };

    // Index width that stays at least one bit for single-lane builds.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iq_lane_compact.sv
// rtl/iq_lane_compact.sv - packs sparse valid input lanes into consecutive write slots
module iq_lane_compact
    import issue_queue_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic [IN_W-1:0]              i_valid,
    output logic [idx_w(IN_W)-1:0]       o_src [IN_W],
    output logic [$clog2(IN_W+1)-1:0]    o_n_enq
);

    localparam int EN_W  = $clog2(IN_W + 1);
    localparam int IDX_W = idx_w(IN_W);

    logic [EN_W-1:0] prefix [IN_W];

    // prefix[i] is the slot lane i lands in when it is valid.
    always_comb begin
        prefix[0] = '0;
        for (int i = 1; i < IN_W; i++) begin
            prefix[i] = prefix[i-1] + EN_W'(i_valid[i-1]);
        end
    end

    always_comb begin
        o_n_enq = prefix[IN_W-1] + EN_W'(i_valid[IN_W-1]);
        for (int s = 0; s < IN_W; s++) begin
            o_src[s] = '0;
            for (int i = 0; i < IN_W; i++) begin
                if (i_valid[i] && (prefix[i] == EN_W'(s))) begin
                    o_src[s] = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order issue buffer between decode and dispatch
// Optional IQ_PERF_EN adds saturating full/empty cycle counters.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IN_W       = 2,
    parameter int OUT_W      = 2,
    parameter int FULL_SLACK = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  PC_set                        i_PC_set [IN_W],
    output logic                         o_enq_ready,
    input  logic [$clog2(OUT_W+1)-1:0]   i_usingNUM,
    input  logic                         flush_BR,
    input  logic                         stall_DCache,
    output PC_set                        o_PC_set [OUT_W],
    output logic [4:0]                   o_rf_raddr1 [OUT_W],
    output logic [4:0]                   o_rf_raddr2 [OUT_W],
    output logic [OUT_W-1:0]             o_is_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_is_full
`ifdef IQ_PERF_EN
    ,
    output logic [31:0]                  o_full_cycles,
    output logic [31:0]                  o_empty_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EN_W  = $clog2(IN_W + 1);
    localparam int IDX_W = idx_w(IN_W);

    PC_set            entries_q [DEPTH];
    PC_set            entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IN_W-1:0]  lane_valid;
    logic [IDX_W-1:0] src [IN_W];
    logic [EN_W-1:0]  n_raw, n_enq;
    logic [CNT_W-1:0] n_deq, avail;

    always_comb begin
        lane_valid = '0;
        for (int k = 0; k < IN_W; k++) begin
            lane_valid[k] = i_PC_set[k].o_valid;
        end
    end

    iq_lane_compact #(
        .IN_W (IN_W)
    ) u_compact (
        .i_valid (lane_valid),
        .o_src   (src),
        .o_n_enq (n_raw)
    );

    assign o_enq_ready = (count_q <= CNT_W'(DEPTH - IN_W));
    assign o_is_full   = (count_q >= CNT_W'(DEPTH - FULL_SLACK));
    assign o_count     = count_q;
    assign n_enq       = o_enq_ready ? n_raw : '0;
    assign avail       = (count_q > CNT_W'(OUT_W)) ? CNT_W'(OUT_W) : count_q;

    always_comb begin
        if (stall_DCache) begin
            n_deq = '0;
        end else if (CNT_W'(i_usingNUM) > count_q) begin
            n_deq = count_q;
        end else begin
            n_deq = CNT_W'(i_usingNUM);
        end
    end

    // Flush rewinds the pointers but leaves entry contents in place.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_BR) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int s = 0; s < IN_W; s++) begin
                if (EN_W'(s) < n_enq) begin
                    entries_d[head_q + PTR_W'(s)] = i_PC_set[src[s]];
                end
            end
            head_d  = head_q + PTR_W'(n_enq);
            tail_d  = tail_q + n_deq[PTR_W-1:0];
            count_d = count_q + CNT_W'(n_enq) - n_deq;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= PC_SET_NOP;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        o_is_valid = '0;
        for (int k = 0; k < OUT_W; k++) begin
            o_PC_set[k]    = entries_q[tail_q + PTR_W'(k)];
            o_rf_raddr1[k] = entries_q[tail_q + PTR_W'(k)].rf_raddr1;
            o_rf_raddr2[k] = entries_q[tail_q + PTR_W'(k)].rf_raddr2;
            o_is_valid[k]  = (count_q > CNT_W'(k));
        end
    end

    usingnum_within_valid: assert property (
        @(posedge clk) disable iff (!rstn) CNT_W'(i_usingNUM) <= avail
    );

`ifdef IQ_PERF_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] empty_cycles_q, empty_cycles_d;

    always_comb begin
        full_cycles_d  = full_cycles_q;
        empty_cycles_d = empty_cycles_q;
        if (!o_enq_ready && (full_cycles_q != '1)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        if ((count_q == '0) && (empty_cycles_q != '1)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_cycles_q  <= '0;
            empty_cycles_q <= '0;
        end else begin
            full_cycles_q  <= full_cycles_d;
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign o_full_cycles  = full_cycles_q;
    assign o_empty_cycles = empty_cycles_q;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    PC_set       i_PC_set [2];
    logic        o_enq_ready;
    logic [1:0]  i_usingNUM;
    logic        flush_BR;
    logic        stall_DCache;
    PC_set       o_PC_set [2];
    logic [4:0]  o_rf_raddr1 [2];
    logic [4:0]  o_rf_raddr2 [2];
    logic [1:0]  o_is_valid;
    logic [4:0]  o_count;
    logic        o_is_full;
`ifdef IQ_PERF_EN
    logic [31:0] o_full_cycles;
    logic [31:0] o_empty_cycles;
    int          m_full = 0;
    int          m_empty = 0;
`endif

    int          total = 0;
    int          bad = 0;
    PC_set       mq [$];
    PC_set       nop;
    PC_set       idle;

    issue_queue dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_PC_set     (i_PC_set),
        .o_enq_ready  (o_enq_ready),
        .i_usingNUM   (i_usingNUM),
        .flush_BR     (flush_BR),
        .stall_DCache (stall_DCache),
        .o_PC_set     (o_PC_set),
        .o_rf_raddr1  (o_rf_raddr1),
        .o_rf_raddr2  (o_rf_raddr2),
        .o_is_valid   (o_is_valid),
        .o_count      (o_count),
        .o_is_full    (o_is_full)
`ifdef IQ_PERF_EN
        ,
        .o_full_cycles  (o_full_cycles),
        .o_empty_cycles (o_empty_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic PC_set mk(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
        PC_set e;
        e           = '0;
        e.pc        = pc;
        e.inst_type = 10'd2;
        e.rf_raddr1 = r1;
        e.rf_raddr2 = r2;
        e.o_valid   = 1'b1;
        return e;
    endfunction

    // Drives one cycle and advances the reference queue model alongside.
    task automatic step(input PC_set l0, input PC_set l1, input int use_n, input bit stall, input bit flush);
        int  nd;
        bit  rdy;
        i_PC_set[0]  = l0;
        i_PC_set[1]  = l1;
        i_usingNUM   = 2'(use_n);
        stall_DCache = stall;
        flush_BR     = flush;
        rdy = (mq.size() <= 14);
`ifdef IQ_PERF_EN
        if (!rdy) m_full++;
        if (mq.size() == 0) m_empty++;
`endif
        if (flush) begin
            mq.delete();
        end else begin
            nd = stall ? 0 : ((use_n > mq.size()) ? mq.size() : use_n);
            for (int i = 0; i < nd; i++) void'(mq.pop_front());
            if (rdy && l0.o_valid) mq.push_back(l0);
            if (rdy && l1.o_valid) mq.push_back(l1);
        end
        @(posedge clk);
        #1;
        i_PC_set[0]  = idle;
        i_PC_set[1]  = idle;
        i_usingNUM   = 2'd0;
        stall_DCache = 1'b0;
        flush_BR     = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_PC_set[0] = idle;
        i_PC_set[1] = idle;
        i_usingNUM = 2'd0;
        stall_DCache = 1'b0;
        flush_BR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        mq.delete();
        total++; if (o_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_is_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", o_is_valid); end
        total++; if (o_enq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_enq_ready); end
        total++; if (o_is_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", o_is_full); end
        total++; if (o_PC_set[0] !== nop) begin bad++; $display("FAIL reset_lane0 got=%0h exp=%0h", o_PC_set[0], nop); end
        total++; if (o_PC_set[1] !== nop) begin bad++; $display("FAIL reset_lane1 got=%0h exp=%0h", o_PC_set[1], nop); end
        total++; if (o_rf_raddr1[0] !== 5'd0 || o_rf_raddr2[1] !== 5'd0) begin
            bad++; $display("FAIL reset_raddr got=%0d/%0d exp=0/0", o_rf_raddr1[0], o_rf_raddr2[1]);
        end
    endtask

    task automatic test_sparse();
        step(idle, mk(32'h1c000004, 5'd3, 5'd4), 0, 0, 0);
        total++; if (o_count !== 5'd1) begin bad++; $display("FAIL sparse_count1 got=%0d exp=1", o_count); end
        total++; if (o_is_valid !== 2'b01) begin bad++; $display("FAIL sparse_valid1 got=%b exp=01", o_is_valid); end
        total++; if (o_PC_set[0].pc !== 32'h1c000004) begin bad++; $display("FAIL sparse_pc1 got=%h exp=1c000004", o_PC_set[0].pc); end
        step(mk(32'h1c000008, 5'd5, 5'd6), mk(32'h1c00000c, 5'd7, 5'd8), 0, 0, 0);
        total++; if (o_count !== 5'd3) begin bad++; $display("FAIL sparse_count3 got=%0d exp=3", o_count); end
        total++; if (o_is_valid !== 2'b11) begin bad++; $display("FAIL sparse_valid3 got=%b exp=11", o_is_valid); end
        total++; if (o_PC_set[0].pc !== 32'h1c000004) begin bad++; $display("FAIL sparse_lane0 got=%h exp=1c000004", o_PC_set[0].pc); end
        total++; if (o_PC_set[1].pc !== 32'h1c000008) begin bad++; $display("FAIL sparse_lane1 got=%h exp=1c000008", o_PC_set[1].pc); end
        total++; if (o_rf_raddr1[0] !== 5'd3 || o_rf_raddr2[0] !== 5'd4) begin
            bad++; $display("FAIL sparse_raddr0 got=%0d/%0d exp=3/4", o_rf_raddr1[0], o_rf_raddr2[0]);
        end
        total++; if (o_rf_raddr1[1] !== 5'd5 || o_rf_raddr2[1] !== 5'd6) begin
            bad++; $display("FAIL sparse_raddr1 got=%0d/%0d exp=5/6", o_rf_raddr1[1], o_rf_raddr2[1]);
        end
        step(idle, idle, 2, 0, 0);
        total++; if (o_count !== 5'd1) begin bad++; $display("FAIL sparse_deq2 got=%0d exp=1", o_count); end
        total++; if (o_PC_set[0].pc !== 32'h1c00000c) begin bad++; $display("FAIL sparse_deq_pc got=%h exp=1c00000c", o_PC_set[0].pc); end
        step(idle, idle, 1, 0, 0);
        total++; if (o_is_valid !== 2'b00) begin bad++; $display("FAIL sparse_empty got=%b exp=00", o_is_valid); end
    endtask

    task automatic test_fill();
        int c;
        int guard;
        for (int i = 0; i < 8; i++) begin
            step(mk(32'h2000 + 32'(8 * i), 5'd1, 5'd2), mk(32'h2004 + 32'(8 * i), 5'd3, 5'd4), 0, 0, 0);
            c = 2 * (i + 1);
            total++; if (o_count !== 5'(c)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", o_count, c); end
            total++; if (o_is_full !== (c >= 10)) begin bad++; $display("FAIL fill_full at=%0d got=%b exp=%b", c, o_is_full, (c >= 10)); end
            total++; if (o_enq_ready !== (c <= 14)) begin bad++; $display("FAIL fill_ready at=%0d got=%b exp=%b", c, o_enq_ready, (c <= 14)); end
        end
        // At 16 the enqueue must be ignored while the dequeue still happens.
        step(mk(32'h3000, 5'd0, 5'd0), mk(32'h3004, 5'd0, 5'd0), 2, 0, 0);
        total++; if (o_count !== 5'd14) begin bad++; $display("FAIL full_ignore_count got=%0d exp=14", o_count); end
        total++; if (o_PC_set[0].pc !== 32'h2008) begin bad++; $display("FAIL full_ignore_pc got=%h exp=2008", o_PC_set[0].pc); end
        step(mk(32'h3008, 5'd0, 5'd0), mk(32'h300c, 5'd0, 5'd0), 2, 0, 0);
        total++; if (o_count !== 5'd14) begin bad++; $display("FAIL overlap_count got=%0d exp=14", o_count); end
        total++; if (o_PC_set[0].pc !== 32'h2010 || o_PC_set[1].pc !== 32'h2014) begin
            bad++; $display("FAIL overlap_pc got=%h/%h exp=2010/2014", o_PC_set[0].pc, o_PC_set[1].pc);
        end
        step(idle, mk(32'h3010, 5'd0, 5'd0), 0, 0, 0);
        total++; if (o_count !== 5'd15) begin bad++; $display("FAIL c15_count got=%0d exp=15", o_count); end
        total++; if (o_enq_ready !== 1'b0 || o_is_full !== 1'b1) begin
            bad++; $display("FAIL c15_flags got=%b/%b exp=0/1", o_enq_ready, o_is_full);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            total++; if (o_PC_set[0].pc !== mq[0].pc) begin bad++; $display("FAIL drain_lane0 got=%h exp=%h", o_PC_set[0].pc, mq[0].pc); end
            if (mq.size() > 1) begin
                total++; if (o_PC_set[1].pc !== mq[1].pc) begin bad++; $display("FAIL drain_lane1 got=%h exp=%h", o_PC_set[1].pc, mq[1].pc); end
            end
            step(idle, idle, (mq.size() > 1) ? 2 : 1, 0, 0);
            guard++;
        end
        total++; if (o_count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        int u;
        pc = 32'h8000;
        for (int i = 0; i < 40; i++) begin
            u = (i % 3 == 0) ? 1 : 2;
            if (u > mq.size()) u = mq.size();
            total++; if (o_count !== 5'(mq.size())) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", i, o_count, mq.size()); end
            if (mq.size() > 0) begin
                total++; if (o_PC_set[0].pc !== mq[0].pc) begin bad++; $display("FAIL wrap_lane0 cyc=%0d got=%h exp=%h", i, o_PC_set[0].pc, mq[0].pc); end
            end
            if (mq.size() > 1) begin
                total++; if (o_PC_set[1].pc !== mq[1].pc) begin bad++; $display("FAIL wrap_lane1 cyc=%0d got=%h exp=%h", i, o_PC_set[1].pc, mq[1].pc); end
            end
            step(mk(pc, 5'(i), 5'd0), mk(pc + 32'd4, 5'd0, 5'(i)), u, 0, 0);
            pc = pc + 32'd8;
        end
        for (int g = 0; g < 20 && mq.size() > 0; g++) begin
            total++; if (o_PC_set[0].pc !== mq[0].pc) begin bad++; $display("FAIL wrap_drain got=%h exp=%h", o_PC_set[0].pc, mq[0].pc); end
            step(idle, idle, (mq.size() > 1) ? 2 : 1, 0, 0);
        end
        total++; if (o_count !== 5'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", o_count); end
    endtask

    task automatic test_stall();
        step(mk(32'h4000, 5'd9, 5'd10), mk(32'h4004, 5'd11, 5'd12), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(mk(32'h4100 + 32'(8 * i), 5'd0, 5'd0), mk(32'h4104 + 32'(8 * i), 5'd0, 5'd0), 2, 1, 0);
            total++; if (o_PC_set[0].pc !== 32'h4000) begin bad++; $display("FAIL stall_tail got=%h exp=4000", o_PC_set[0].pc); end
        end
        total++; if (o_count !== 5'd8) begin bad++; $display("FAIL stall_count got=%0d exp=8", o_count); end
        step(idle, idle, 2, 0, 0);
        total++; if (o_count !== 5'd6) begin bad++; $display("FAIL unstall_count got=%0d exp=6", o_count); end
        total++; if (o_PC_set[0].pc !== 32'h4100) begin bad++; $display("FAIL unstall_pc got=%h exp=4100", o_PC_set[0].pc); end
    endtask

    task automatic test_flush();
        step(mk(32'h4200, 5'd0, 5'd0), idle, 0, 0, 0);
        total++; if (o_count !== 5'd7) begin bad++; $display("FAIL preflush_count got=%0d exp=7", o_count); end
        step(mk(32'h4300, 5'd0, 5'd0), mk(32'h4304, 5'd0, 5'd0), 1, 0, 1);
        total++; if (o_count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        total++; if (o_is_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", o_is_valid); end
        total++; if (o_enq_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", o_enq_ready); end
`ifdef IQ_PERF_EN
        total++; if (o_full_cycles !== 32'(m_full)) begin bad++; $display("FAIL flush_perf_full got=%0d exp=%0d", o_full_cycles, m_full); end
        total++; if (o_empty_cycles !== 32'(m_empty)) begin bad++; $display("FAIL flush_perf_empty got=%0d exp=%0d", o_empty_cycles, m_empty); end
`endif
        step(mk(32'h5000, 5'd13, 5'd14), idle, 0, 0, 0);
        total++; if (o_count !== 5'd1 || o_PC_set[0].pc !== 32'h5000) begin
            bad++; $display("FAIL postflush got=%0d/%h exp=1/5000", o_count, o_PC_set[0].pc);
        end
    endtask

    task automatic test_reset_mid();
        step(mk(32'h5004, 5'd0, 5'd0), idle, 0, 0, 0);
        rstn = 1'b0;
        #2;
        mq.delete();
`ifdef IQ_PERF_EN
        m_full = 0;
        m_empty = 0;
`endif
        total++; if (o_count !== 5'd0 || o_is_valid !== 2'b00) begin
            bad++; $display("FAIL async_reset got=%0d/%b exp=0/00", o_count, o_is_valid);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(mk(32'h6000, 5'd15, 5'd16), idle, 0, 0, 0);
        total++; if (o_count !== 5'd1 || o_PC_set[0].pc !== 32'h6000) begin
            bad++; $display("FAIL rst_first got=%0d/%h exp=1/6000", o_count, o_PC_set[0].pc);
        end
        total++; if (o_PC_set[1] !== nop) begin bad++; $display("FAIL rst_lane1_nop got=%0h exp=%0h", o_PC_set[1], nop); end
`ifdef IQ_PERF_EN
        total++; if (o_empty_cycles !== 32'(m_empty)) begin bad++; $display("FAIL rst_perf_empty got=%0d exp=%0d", o_empty_cycles, m_empty); end
`endif
    endtask

    initial begin
        nop = '0;
        nop.inst_type = 10'd1;
        idle = '0;
        test_reset();
        test_sparse();
        test_fill();
        test_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
